// File: rtl/uart_core.sv
// uart_core: 16x-oversampled UART with one FIFO per direction and sticky receive error flags.
// Defining UART_PARITY_EN adds a parity bit (even or odd, per PARITY_ODD) to every frame.

module uart_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          wr,
    input  logic [DW-1:0] w_data,
    input  logic          rd,
    output logic [DW-1:0] r_data,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem_r [0:(2**AW)-1];
    logic [AW:0]   wptr_r;
    logic [AW:0]   rptr_r;
    logic          wr_acc_s;
    logic          rd_acc_s;

    assign full     = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign empty    = (wptr_r == rptr_r);
    // A full FIFO still takes a write when the same cycle pops the head.
    assign wr_acc_s = wr && (!full || rd);
    assign rd_acc_s = rd && !empty;
    assign r_data   = empty ? {DW{1'b0}} : mem_r[rptr_r[AW-1:0]];

    // Storage array write port
    always_ff @(posedge clock) begin
        if (wr_acc_s) begin
            mem_r[wptr_r[AW-1:0]] <= w_data;
        end
    end

    // Read and write pointers, one extra bit to tell full from empty
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r <= {(AW+1){1'b0}};
            rptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_acc_s) begin
                wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (rd_acc_s) begin
                rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end
endmodule

module uart_core #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int DVSR       = 163,
    parameter int ADDR_W     = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            rx,
    output logic            tx,
    input  logic [DBIT-1:0] w_data,
    input  logic            wr,
    output logic            tx_full,
    output logic [DBIT-1:0] r_data,
    input  logic            rd,
    output logic            rx_empty,
    output logic            rx_overrun,
    output logic            frame_err,
    output logic            parity_err
);
    localparam int            TW        = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DVSR - 1);
    localparam logic [4:0]    SB_LAST   = 5'(SB_TICK - 1);
    localparam logic [3:0]    N_LAST    = 4'(DBIT - 1);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    function automatic logic par_bit(input logic [DBIT-1:0] d);
        par_bit = (^d) ^ (PARITY_ODD != 0);
    endfunction

    logic [TW-1:0]   tick_cnt_r;
    logic            tick_s;
    logic            rx_meta_r;
    logic            rx_sync_r;

    rx_state_t       rx_state_r;
    logic [4:0]      rx_s_r;
    logic [3:0]      rx_n_r;
    logic [DBIT-1:0] rx_b_r;
    logic            rx_done_r;
    logic            overrun_r;
    logic            frame_err_r;
    logic            rx_full_s;
    logic            rd_acc_s;

    tx_state_t       tx_state_r;
    logic [4:0]      tx_s_r;
    logic [3:0]      tx_n_r;
    logic [DBIT-1:0] tx_b_r;
    logic            tx_r;
    logic            tx_pop_s;
    logic            tx_empty_s;
    logic [DBIT-1:0] tx_head_s;
`ifdef UART_PARITY_EN
    logic            tx_par_r;
    logic            parity_err_r;
`endif

    assign tick_s     = (tick_cnt_r == TICK_LAST);
    assign rd_acc_s   = rd && !rx_empty;
    assign tx         = tx_r;
    assign rx_overrun = overrun_r;
    assign frame_err  = frame_err_r;
`ifdef UART_PARITY_EN
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    // Baud tick generator
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_r <= {TW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Two-flop synchroniser for the asynchronous receive line
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM plus sticky error flags; later set assignments override the rd clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_r   <= RX_IDLE;
            rx_s_r       <= 5'd0;
            rx_n_r       <= 4'd0;
            rx_b_r       <= {DBIT{1'b0}};
            rx_done_r    <= 1'b0;
            overrun_r    <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            rx_done_r <= 1'b0;
            if (rd_acc_s) begin
                overrun_r    <= 1'b0;
                frame_err_r  <= 1'b0;
`ifdef UART_PARITY_EN
                parity_err_r <= 1'b0;
`endif
            end
            if (rx_done_r && rx_full_s && !rd) begin
                overrun_r <= 1'b1;
            end
            case (rx_state_r)
                RX_IDLE: begin
                    if (!rx_sync_r) begin
                        rx_state_r <= RX_START;
                        rx_s_r     <= 5'd0;
                    end
                end
                RX_START: begin
                    if (tick_s) begin
                        if (rx_s_r == 5'd7) begin
                            rx_s_r     <= 5'd0;
                            rx_n_r     <= 4'd0;
                            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_s_r <= rx_s_r + 5'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick_s) begin
                        if (rx_s_r == 5'd15) begin
                            rx_s_r <= 5'd0;
                            rx_b_r <= {rx_sync_r, rx_b_r[DBIT-1:1]};
                            if (rx_n_r == N_LAST) begin
`ifdef UART_PARITY_EN
                                rx_state_r <= RX_PARITY;
`else
                                rx_state_r <= RX_STOP;
`endif
                            end else begin
                                rx_n_r <= rx_n_r + 4'd1;
                            end
                        end else begin
                            rx_s_r <= rx_s_r + 5'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (tick_s) begin
                        if (rx_s_r == 5'd15) begin
                            rx_s_r     <= 5'd0;
                            rx_state_r <= RX_STOP;
                            if (rx_sync_r != par_bit(rx_b_r)) begin
                                parity_err_r <= 1'b1;
                            end
                        end else begin
                            rx_s_r <= rx_s_r + 5'd1;
                        end
                    end
                end
`endif
                RX_STOP: begin
                    if (tick_s) begin
                        // Sixteen ticks past the last data midpoint is the stop-bit midpoint.
                        if ((rx_s_r == 5'd15) && !rx_sync_r) begin
                            frame_err_r <= 1'b1;
                        end
                        if (rx_s_r == SB_LAST) begin
                            rx_state_r <= RX_IDLE;
                            rx_done_r  <= 1'b1;
                        end else begin
                            rx_s_r <= rx_s_r + 5'd1;
                        end
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    uart_fifo #(.DW(DBIT), .AW(ADDR_W)) u_rx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr      (rx_done_r),
        .w_data  (rx_b_r),
        .rd      (rd),
        .r_data  (r_data),
        .full    (rx_full_s),
        .empty   (rx_empty)
    );

    uart_fifo #(.DW(DBIT), .AW(ADDR_W)) u_tx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr      (wr),
        .w_data  (w_data),
        .rd      (tx_pop_s),
        .r_data  (tx_head_s),
        .full    (tx_full),
        .empty   (tx_empty_s)
    );

    // Pop decision: from idle, or at the end of a stop period for gap-free frames
    always_comb begin
        tx_pop_s = 1'b0;
        if (tick_s && !tx_empty_s) begin
            if (tx_state_r == TX_IDLE) begin
                tx_pop_s = 1'b1;
            end else if ((tx_state_r == TX_STOP) && (tx_s_r == SB_LAST)) begin
                tx_pop_s = 1'b1;
            end else begin
                tx_pop_s = 1'b0;
            end
        end else begin
            tx_pop_s = 1'b0;
        end
    end

    // Transmit FSM with registered serial output
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_r <= TX_IDLE;
            tx_s_r     <= 5'd0;
            tx_n_r     <= 4'd0;
            tx_b_r     <= {DBIT{1'b0}};
            tx_r       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_r   <= 1'b0;
`endif
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_r <= 1'b1;
                    if (tx_pop_s) begin
                        tx_state_r <= TX_START;
                        tx_s_r     <= 5'd0;
                        tx_b_r     <= tx_head_s;
                        tx_r       <= 1'b0;
`ifdef UART_PARITY_EN
                        tx_par_r   <= par_bit(tx_head_s);
`endif
                    end
                end
                TX_START: begin
                    if (tick_s) begin
                        if (tx_s_r == 5'd15) begin
                            tx_s_r     <= 5'd0;
                            tx_n_r     <= 4'd0;
                            tx_state_r <= TX_DATA;
                            tx_r       <= tx_b_r[0];
                        end else begin
                            tx_s_r <= tx_s_r + 5'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick_s) begin
                        if (tx_s_r == 5'd15) begin
                            tx_s_r <= 5'd0;
                            tx_b_r <= tx_b_r >> 1;
                            if (tx_n_r == N_LAST) begin
`ifdef UART_PARITY_EN
                                tx_state_r <= TX_PARITY;
                                tx_r       <= tx_par_r;
`else
                                tx_state_r <= TX_STOP;
                                tx_r       <= 1'b1;
`endif
                            end else begin
                                tx_n_r <= tx_n_r + 4'd1;
                                tx_r   <= tx_b_r[1];
                            end
                        end else begin
                            tx_s_r <= tx_s_r + 5'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (tick_s) begin
                        if (tx_s_r == 5'd15) begin
                            tx_s_r     <= 5'd0;
                            tx_state_r <= TX_STOP;
                            tx_r       <= 1'b1;
                        end else begin
                            tx_s_r <= tx_s_r + 5'd1;
                        end
                    end
                end
`endif
                TX_STOP: begin
                    if (tick_s) begin
                        if (tx_s_r == SB_LAST) begin
                            tx_s_r <= 5'd0;
                            if (tx_pop_s) begin
                                tx_state_r <= TX_START;
                                tx_b_r     <= tx_head_s;
                                tx_r       <= 1'b0;
`ifdef UART_PARITY_EN
                                tx_par_r   <= par_bit(tx_head_s);
`endif
                            end else begin
                                tx_state_r <= TX_IDLE;
                                tx_r       <= 1'b1;
                            end
                        end else begin
                            tx_s_r <= tx_s_r + 5'd1;
                        end
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// Randomised bench for uart_core: loopback, TX FIFO fill, glitch, framing, overrun and parity cases,
// checked against frame-level queues and a serial-line decoder.
`timescale 1ns/1ps
module tb_uart_core;
    localparam int DBIT       = 8;
    localparam int SB_TICK    = 16;
    localparam int DVSR       = 2;
    localparam int ADDR_W     = 4;
    localparam int PARITY_ODD = 0;
    localparam int BIT        = 16 * DVSR;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_drv  = 1'b1;
    logic       loop_en = 1'b0;
    logic       wr      = 1'b0;
    logic       rd      = 1'b0;
    logic [7:0] w_data  = 8'h00;
    logic       rx_line;
    logic       tx;
    logic       tx_full;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rx_overrun;
    logic       frame_err;
    logic       parity_err;

    int         err_cnt = 0;
    int         chk_cnt = 0;
    int         dec_cnt = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    assign rx_line = loop_en ? tx : rx_drv;

    uart_core #(
        .DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR), .ADDR_W(ADDR_W), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx         (rx_line),
        .tx         (tx),
        .w_data     (w_data),
        .wr         (wr),
        .tx_full    (tx_full),
        .r_data     (r_data),
        .rd         (rd),
        .rx_empty   (rx_empty),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_par(input logic [7:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    task automatic write_word(input logic [7:0] d);
        @(negedge clock);
        w_data = d;
        wr     = 1'b1;
        @(negedge clock);
        wr     = 1'b0;
    endtask

    task automatic read_word();
        @(negedge clock);
        rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        logic pb;
        pb = model_par(d) ^ par_flip;
        @(negedge clock);
        rx_drv = 1'b0;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BIT) @(negedge clock);
        end
`ifdef UART_PARITY_EN
        rx_drv = pb;
        repeat (BIT) @(negedge clock);
`endif
        rx_drv = stop_v;
        repeat (BIT) @(negedge clock);
        rx_drv = 1'b1;
    endtask

    task automatic wait_rx(input string tag);
        int n;
        n = 0;
        while (rx_empty && n < 4 * BIT) begin
            @(negedge clock);
            n++;
        end
        check_eq(tag, rx_empty, 1'b0);
    endtask

    // Serial decoder on tx: each frame must match the next word the bench wrote
    initial begin : tx_decoder
        logic [7:0] d;
        @(posedge reset_n);
        forever begin
            @(negedge tx);
            repeat (BIT / 2) @(negedge clock);
            check_eq("tx_start_bit", tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clock);
                d[i] = tx;
            end
`ifdef UART_PARITY_EN
            repeat (BIT) @(negedge clock);
            check_eq("tx_parity_bit", tx, model_par(d));
`endif
            repeat (BIT) @(negedge clock);
            check_eq("tx_stop_bit", tx, 1'b1);
            dec_cnt++;
            check_eq("tx_frame_expected", tx_exp.size() > 0, 1'b1);
            if (tx_exp.size() > 0) begin
                check_eq("tx_word", d, tx_exp.pop_front());
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] d;
        int         lat;
        int         base;

        repeat (3) @(negedge clock);
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_tx_full", tx_full, 1'b0);
        check_eq("rst_rx_empty", rx_empty, 1'b1);
        check_eq("rst_r_data", r_data, 8'h00);
        check_eq("rst_overrun", rx_overrun, 1'b0);
        check_eq("rst_frame_err", frame_err, 1'b0);
        check_eq("rst_parity_err", parity_err, 1'b0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // rd on an empty FIFO is ignored
        read_word();
        check_eq("rd_empty_ignored", rx_empty, 1'b1);
        check_eq("rd_empty_r_data", r_data, 8'h00);

        // Loopback: first word 0xA5, then random words
        loop_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            tx_exp.push_back(d);
            rx_exp.push_back(d);
            write_word(d);
            lat = 0;
            while (rx_empty && lat < 20 * BIT) begin
                @(negedge clock);
                lat++;
            end
            check_eq("loop_arrive", rx_empty, 1'b0);
            if (i == 0) begin
                check_eq("loop_a5_latency", (lat >= (NBITS - 1) * BIT) && (lat <= (NBITS + 1) * BIT), 1'b1);
            end
            check_eq("loop_word", r_data, rx_exp.pop_front());
            read_word();
            check_eq("loop_empty_after_rd", rx_empty, 1'b1);
            repeat (BIT) @(negedge clock);
        end
        loop_en = 1'b0;

        // Fill the TX FIFO while a frame is in flight
        base = dec_cnt;
        d = 8'($urandom_range(0, 255));
        tx_exp.push_back(d);
        write_word(d);
        lat = 0;
        while (tx && lat < 4 * BIT) begin
            @(negedge clock);
            lat++;
        end
        check_eq("tx_busy", tx, 1'b0);
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom_range(0, 255));
            if (i < 16) tx_exp.push_back(d);
            w_data = d;
            wr     = 1'b1;
            @(negedge clock);
            check_eq("tx_full_fill", tx_full, i >= 15);
        end
        wr  = 1'b0;
        lat = 0;
        while (tx_exp.size() > 0 && lat < 20 * NBITS * BIT) begin
            @(negedge clock);
            lat++;
        end
        repeat (2 * BIT) @(negedge clock);
        check_eq("tx_frames_sent", dec_cnt - base, 17);
        check_eq("tx_queue_drained", tx_exp.size(), 0);
        check_eq("tx_full_after", tx_full, 1'b0);

        // Start glitch of 5 ticks must be rejected
        @(negedge clock);
        rx_drv = 1'b0;
        repeat (5 * DVSR) @(negedge clock);
        rx_drv = 1'b1;
        repeat (2 * BIT) @(negedge clock);
        check_eq("glitch_no_push", rx_empty, 1'b1);
        check_eq("glitch_no_frame_err", frame_err, 1'b0);
        d = 8'($urandom_range(0, 255));
        send_frame(d, 1'b1, 1'b0);
        wait_rx("after_glitch_arrive");
        check_eq("after_glitch_word", r_data, d);
        read_word();

        // Stop bit held low
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_rx("ferr_arrive");
        repeat (BIT) @(negedge clock);
        check_eq("ferr_word", r_data, 8'h3C);
        check_eq("ferr_flag", frame_err, 1'b1);
        read_word();
        check_eq("ferr_cleared", frame_err, 1'b0);
        check_eq("ferr_empty", rx_empty, 1'b1);

        // 17 frames with no reads: the 17th is dropped
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1, 1'b0);
            if (i < 16) rx_exp.push_back(d);
            if (i == 15) begin
                repeat (4) @(negedge clock);
                check_eq("ovr_not_yet", rx_overrun, 1'b0);
            end
        end
        repeat (BIT) @(negedge clock);
        check_eq("ovr_flag", rx_overrun, 1'b1);
        check_eq("ovr_frame_err", frame_err, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check_eq("ovr_word", r_data, rx_exp.pop_front());
            read_word();
            if (i == 0) check_eq("ovr_cleared", rx_overrun, 1'b0);
        end
        check_eq("ovr_drained", rx_empty, 1'b1);

`ifdef UART_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1);
        wait_rx("par_arrive");
        check_eq("par_word", r_data, 8'h01);
        check_eq("par_flag", parity_err, 1'b1);
        read_word();
        check_eq("par_cleared", parity_err, 1'b0);
`else
        check_eq("parity_err_tied", parity_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter SB_TICK, default 16, oversample ticks in stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL have parameter DVSR, default 163, clock cycles per 16x oversample tick (>= 2).
REQ-004 SHALL have parameter ADDR_W, default 4, FIFO depth 2**ADDR_W entries, each direction.
REQ-005 SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity (used only with UART_PARITY_EN).
REQ-006 SHALL have port clock  input  1  single system clock, rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port rx  input  1  serial receive line, asynchronous, idle high.
REQ-009 SHALL have port tx  output  1  serial transmit line, idle high.
REQ-010 SHALL have port w_data  input  DBIT  byte to transmit.
REQ-011 SHALL have port wr  input  1  push w_data into TX FIFO.
REQ-012 SHALL have port tx_full  output  1  TX FIFO full.
REQ-013 SHALL have port r_data  output  DBIT  head of RX FIFO (first-word fall-through).
REQ-014 SHALL have port rd  input  1  pop RX FIFO head.
REQ-015 SHALL have port rx_empty  output  1  RX FIFO empty.
REQ-016 SHALL have port rx_overrun  output  1  sticky: a received frame was dropped because the RX FIFO was full.
REQ-017 SHALL have port frame_err  output  1  sticky: a stop bit was sampled low.
REQ-018 SHALL have port parity_err  output  1  sticky: received parity mismatch.

Function
REQ-019 SHALL run a tick counter 0..DVSR-1 and pulse tick for one clock when count = DVSR-1.
REQ-020 SHALL pass rx through a 2-flop synchroniser (reset value 1); all RX decisions use the synchronised value.
REQ-021 SHALL implement RX FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE -> START on synchronised rx = 0.
- START: at tick 7, rx = 0 -> DATA; rx = 1 -> IDLE (glitch rejected).
- DATA: sample every 16th tick, LSB first, DBIT bits.
- STOP: wait SB_TICK ticks; sample rx at the stop-bit midpoint.
REQ-022 SHALL push the assembled word into the RX FIFO on the clock after STOP completes, even when frame_err is set.
REQ-023 SHALL, when the RX FIFO is full at push time, drop the word and set rx_overrun.
REQ-024 SHALL implement TX FSM IDLE -> START -> DATA -> [PARITY] -> STOP; each bit lasts 16 ticks; stop lasts SB_TICK ticks.
REQ-025 SHALL, in IDLE with the TX FIFO non-empty, pop one word and begin the start bit at the next tick; back-to-back frames have no idle gap.
REQ-026 SHALL ignore wr while tx_full and rd while rx_empty.
REQ-027 SHALL honour simultaneous read and write on any FIFO.
- Not empty and not full: occupancy unchanged.
- Full: the read frees a slot and the write succeeds.
- Empty: write only.
REQ-028 SHALL wrap FIFO pointers modulo 2**ADDR_W using an extra pointer bit for full/empty.
REQ-029 SHALL clear rx_overrun, frame_err and parity_err on any accepted rd; if a set event coincides with that rd, the set wins.

Reset
REQ-030 SHALL on reset_n = 0 immediately force tx = 1, tx_full = 0, rx_empty = 1, r_data = 0, all error flags 0, both FSMs IDLE, FIFOs empty, tick counter 0.
REQ-031 SHALL abort any frame in progress on reset; after release the RX FSM waits for a fresh falling edge.

Configuration
REQ-032 SHALL honour macro UART_PARITY_EN.
- Defined: a parity bit (per PARITY_ODD) is sent after the data bits and checked on receive; a mismatch sets parity_err and still pushes the word.
- Undefined: no parity state in either FSM, and parity_err is tied 0.

Verification
REQ-033 SHALL pass, DVSR=2 and loopback tx->rx: write 0xA5 -> 0xA5 appears at r_data with rx_empty = 0 after 10 bit times (11 with parity).
REQ-034 SHALL pass: write 17 words with ADDR_W=4 while TX is busy -> tx_full rises after the 16th word and the 17th is ignored; exactly 16 frames are sent.
REQ-035 SHALL pass: drive rx low for 5 ticks, then high -> no word is pushed and the RX FSM returns to IDLE.
REQ-036 SHALL pass: send 0x3C with stop bit held low -> 0x3C is pushed and frame_err = 1; the next rd clears it.
REQ-037 SHALL pass: 17 frames into the RX FIFO with no rd -> rx_overrun = 1 and the FIFO holds the first 16.
REQ-038 SHALL pass, UART_PARITY_EN defined with PARITY_ODD=0: send 0x01 with parity bit 0 -> parity_err = 1.
